// File: rtl/exe_stage_md.sv
// Execute stage: forwarding, ALU, destination select and an
// iterative unsigned multiply/divide unit writing HI/LO.
module exe_stage_md #(
  parameter int WIDTH = 32,
  parameter int REGW  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_exe,
  input  logic             regdst_exe,
  input  logic             alusrc_exe,
  input  logic [3:0]       alucontrol_exe,
  input  logic [2:0]       mdop_exe,
  input  logic [REGW-1:0]  Rt_exe,
  input  logic [REGW-1:0]  Rd_exe,
  input  logic [4:0]       shamt_exe,
  input  logic [WIDTH-1:0] data1_exe,
  input  logic [WIDTH-1:0] data2_exe,
  input  logic [WIDTH-1:0] signext_exe,
  input  logic [WIDTH-1:0] result_wb,
  input  logic [WIDTH-1:0] aluout_mem,
  input  logic [1:0]       forwardA_exe,
  input  logic [1:0]       forwardB_exe,
  output logic [REGW-1:0]  regaddr_exe,
  output logic [WIDTH-1:0] aluout_exe,
  output logic [WIDTH-1:0] writedata_exe,
  output logic             stall_exe,
  output logic             md_busy
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state, state_nx;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   hi, lo, op_a, op_b;
  logic [2*WIDTH-1:0] acc, acc_nx;
  logic               is_mul;
  logic [WIDTH-1:0]   val_a, alu_b, alu_res;
  logic [WIDTH:0]     mul_sum, div_sh;
  logic [WIDTH+1:0]   div_diff;
  logic               op_mul, op_div, issue, last;

  assign op_mul = valid_exe && (mdop_exe == 3'b001);
  assign op_div = valid_exe && (mdop_exe == 3'b010);
  assign issue  = !rst && (op_mul || op_div);
  assign last   = (cnt == CW'(WIDTH - 1));

  // operand forwarding muxes
  always_comb begin
    val_a = '0;
    writedata_exe = '0;
    case (forwardA_exe)
      2'b00: val_a = data1_exe;
      2'b01: val_a = result_wb;
      2'b10: val_a = aluout_mem;
      default: val_a = '0;
    endcase
    case (forwardB_exe)
      2'b00: writedata_exe = data2_exe;
      2'b01: writedata_exe = result_wb;
      2'b10: writedata_exe = aluout_mem;
      default: writedata_exe = '0;
    endcase
  end

  assign alu_b       = alusrc_exe ? signext_exe : writedata_exe;
  assign regaddr_exe = regdst_exe ? Rd_exe : Rt_exe;

  // single-cycle ALU
  always_comb begin
    alu_res = '0;
    case (alucontrol_exe)
      4'b0000: alu_res = val_a & alu_b;
      4'b0001: alu_res = val_a | alu_b;
      4'b0010: alu_res = val_a + alu_b;
      4'b0011: alu_res = val_a ^ alu_b;
      4'b0100: alu_res = ~(val_a | alu_b);
      4'b0101: alu_res = alu_b << shamt_exe;
      4'b0110: alu_res = val_a - alu_b;
      4'b0111: alu_res = {{(WIDTH-1){1'b0}},
                          $signed(val_a) < $signed(alu_b)};
      4'b1000: alu_res = alu_b >> shamt_exe;
      4'b1001: alu_res = $signed(alu_b) >>> shamt_exe;
      4'b1010: alu_res = {{(WIDTH-1){1'b0}}, val_a < alu_b};
      default: alu_res = '0;
    endcase
  end

  // MFHI/MFLO bypass the ALU
  always_comb begin
    aluout_exe = alu_res;
    if (valid_exe && mdop_exe == 3'b011) aluout_exe = hi;
    if (valid_exe && mdop_exe == 3'b100) aluout_exe = lo;
  end

  // one shift-add or restoring-divide step
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]}
             + (acc[0] ? {1'b0, op_a} : '0);
    div_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff = {1'b0, div_sh} - {2'b00, op_b};
    if (is_mul)
      acc_nx = {mul_sum, acc[WIDTH-1:1]};
    else if (div_diff[WIDTH+1])
      acc_nx = {div_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    else
      acc_nx = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (issue) state_nx = BUSY;
      BUSY:    if (last)  state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  // FSM, counter and latched operands
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      op_a   <= '0;
      op_b   <= '0;
      acc    <= '0;
      is_mul <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && issue) begin
        op_a   <= val_a;
        op_b   <= writedata_exe;
        is_mul <= op_mul;
        acc    <= {{WIDTH{1'b0}},
                   op_mul ? writedata_exe : val_a};
        cnt    <= '0;
      end else if (state == BUSY) begin
        acc <= acc_nx;
        cnt <= cnt + 1'b1;
      end
    end
  end

  // HI/LO: unit result has priority over MTHI/MTLO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else if (state == BUSY && last) begin
      hi <= acc_nx[2*WIDTH-1:WIDTH];
      lo <= acc_nx[WIDTH-1:0];
    end else if (valid_exe && mdop_exe == 3'b101) begin
      hi <= val_a;
    end else if (valid_exe && mdop_exe == 3'b110) begin
      lo <= val_a;
    end
  end

  assign stall_exe = (state == IDLE && issue) || (state == BUSY);
  assign md_busy   = (state != IDLE);

endmodule

// File: tb/tb_exe_stage_md.sv
// Bench for exe_stage_md: reference model with per-cycle
// compare plus directed vectors at WIDTH 32 and 16.
module tb_exe_stage_md;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        valid, regdst, alusrc;
  logic [3:0]  aluc;
  logic [2:0]  mdop;
  logic [4:0]  rt, rd, shamt;
  logic [31:0] d1, d2, sx, rwb, amem;
  logic [1:0]  fa, fb;
  logic [4:0]  regaddr;
  logic [31:0] aluout, wdata;
  logic        stall, busy;

  logic        v16;
  logic [2:0]  op16;
  logic [15:0] a16, b16;
  logic [4:0]  ra16;
  logic [15:0] alu16, wd16;
  logic        st16, bz16;

  int n_cmp = 0;
  int n_bad = 0;

  exe_stage_md #(.WIDTH(32), .REGW(5)) u_dut (
    .clk(clk), .rst(rst), .valid_exe(valid),
    .regdst_exe(regdst), .alusrc_exe(alusrc),
    .alucontrol_exe(aluc), .mdop_exe(mdop),
    .Rt_exe(rt), .Rd_exe(rd), .shamt_exe(shamt),
    .data1_exe(d1), .data2_exe(d2), .signext_exe(sx),
    .result_wb(rwb), .aluout_mem(amem),
    .forwardA_exe(fa), .forwardB_exe(fb),
    .regaddr_exe(regaddr), .aluout_exe(aluout),
    .writedata_exe(wdata), .stall_exe(stall),
    .md_busy(busy)
  );

  exe_stage_md #(.WIDTH(16), .REGW(5)) u_d16 (
    .clk(clk), .rst(rst), .valid_exe(v16),
    .regdst_exe(1'b0), .alusrc_exe(1'b0),
    .alucontrol_exe(4'd0), .mdop_exe(op16),
    .Rt_exe(5'd0), .Rd_exe(5'd0), .shamt_exe(5'd0),
    .data1_exe(a16), .data2_exe(b16), .signext_exe(16'd0),
    .result_wb(16'd0), .aluout_mem(16'd0),
    .forwardA_exe(2'b00), .forwardB_exe(2'b00),
    .regaddr_exe(ra16), .aluout_exe(alu16),
    .writedata_exe(wd16), .stall_exe(st16),
    .md_busy(bz16)
  );

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] fwd(input logic [1:0] s,
                                      input logic [31:0] r);
    case (s)
      2'b00:   return r;
      2'b01:   return rwb;
      2'b10:   return amem;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] alu(input logic [31:0] a,
                                      input logic [31:0] b,
                                      input logic [3:0] c,
                                      input logic [4:0] sh);
    case (c)
      4'd0:  return a & b;
      4'd1:  return a | b;
      4'd2:  return a + b;
      4'd3:  return a ^ b;
      4'd4:  return ~(a | b);
      4'd5:  return b << sh;
      4'd6:  return a - b;
      4'd7:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd8:  return b >> sh;
      4'd9:  return 32'($signed(b) >>> sh);
      4'd10: return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // reference model: HI/LO plus cycles left in the md op
  int          m_rem;
  logic [31:0] m_hi, m_lo, p_hi, p_lo;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_rem <= 0;
      m_hi  <= '0;
      m_lo  <= '0;
      p_hi  <= '0;
      p_lo  <= '0;
    end else if (m_rem == 0) begin
      if (valid && mdop == 3'd1) begin
        m_rem <= W + 1;
        {p_hi, p_lo} <= 64'(fwd(fa, d1)) * 64'(fwd(fb, d2));
      end else if (valid && mdop == 3'd2) begin
        m_rem <= W + 1;
        if (fwd(fb, d2) == 0) begin
          p_hi <= fwd(fa, d1);
          p_lo <= 32'hFFFF_FFFF;
        end else begin
          p_hi <= fwd(fa, d1) % fwd(fb, d2);
          p_lo <= fwd(fa, d1) / fwd(fb, d2);
        end
      end else if (valid && mdop == 3'd5) begin
        m_hi <= fwd(fa, d1);
      end else if (valid && mdop == 3'd6) begin
        m_lo <= fwd(fa, d1);
      end
    end else begin
      m_rem <= m_rem - 1;
      if (m_rem == 2) begin
        m_hi <= p_hi;
        m_lo <= p_lo;
      end
    end
  end

  logic [31:0] e_va, e_wd, e_alu;
  logic        e_st;

  // compare every cycle against the model
  always @(negedge clk) begin
    e_va = fwd(fa, d1);
    e_wd = fwd(fb, d2);
    if (valid && mdop == 3'd3)      e_alu = m_hi;
    else if (valid && mdop == 3'd4) e_alu = m_lo;
    else e_alu = alu(e_va, alusrc ? sx : e_wd, aluc, shamt);
    e_st = !rst && ((m_rem == 0 && valid &&
           (mdop == 3'd1 || mdop == 3'd2)) || m_rem >= 2);
    chk("aluout", 64'(aluout), 64'(e_alu));
    chk("writedata", 64'(wdata), 64'(e_wd));
    chk("regaddr", 64'(regaddr), 64'(regdst ? rd : rt));
    chk("stall", 64'(stall), 64'(e_st));
    chk("md_busy", 64'(busy), 64'(m_rem != 0));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic vec(input string nm, input logic [31:0] exp);
    @(negedge clk);
    chk(nm, 64'(aluout), 64'(exp));
    step();
  endtask

  task automatic run_md(input string nm, input logic [2:0] op,
                        input logic [1:0] sa,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi,
                        input logic [31:0] elo,
                        input bit poke);
    int n;
    bit done;
    n = 0;
    done = 0;
    valid = 1; mdop = op; aluc = 4'd2; alusrc = 0;
    fa = sa; fb = 2'b00; d2 = b;
    if (sa == 2'b10) amem = a; else d1 = a;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (!stall) done = 1;
      else begin
        n++;
        step();
        if (poke && i == 3) amem = 32'h55;
      end
    end
    chk({nm, "_ended"}, 64'(done), 64'd1);
    chk({nm, "_stall_cycles"}, 64'(n), 64'd33);
    step();
    fa = 2'b00; mdop = 3'd4;
    @(negedge clk);
    chk({nm, "_lo"}, 64'(aluout), 64'(elo));
    step();
    mdop = 3'd3;
    @(negedge clk);
    chk({nm, "_hi"}, 64'(aluout), 64'(ehi));
    step();
    mdop = 3'd0;
  endtask

  initial begin
    int n;
    bit done;
    valid = 0; regdst = 0; alusrc = 0; aluc = 0; mdop = 0;
    rt = 0; rd = 0; shamt = 0; d1 = 0; d2 = 0; sx = 0;
    rwb = 0; amem = 0; fa = 0; fb = 0;
    v16 = 0; op16 = 0; a16 = 0; b16 = 0;
    #1 rst = 1;
    #1;
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    step();
    rst = 0;
    step();

    valid = 1; mdop = 3'd4;
    vec("reset_lo", 32'd0);
    mdop = 3'd0;

    aluc = 4'd2; d1 = 5; d2 = 7;
    vec("add", 32'd12);
    aluc = 4'd6; d1 = 3; d2 = 5;
    vec("sub", 32'hFFFF_FFFE);
    aluc = 4'd7; d1 = 32'hFFFF_FFFF; d2 = 1;
    vec("slt", 32'd1);
    aluc = 4'd10;
    vec("sltu", 32'd0);
    aluc = 4'd5; d2 = 1; shamt = 4;
    vec("sll", 32'd16);
    aluc = 4'd9; d2 = 32'h8000_0000;
    vec("sra", 32'hF800_0000);
    aluc = 4'd2; alusrc = 1; d1 = 10; sx = 32'hFFFF_FFFF;
    vec("addi", 32'd9);
    alusrc = 0; fa = 2'b01; fb = 2'b11; rwb = 32'h100;
    vec("fwd_wb", 32'h100);
    fa = 2'b11; fb = 2'b01; rt = 3; rd = 9; regdst = 1;
    vec("fwd_zero", 32'h100);
    fa = 0; fb = 0; regdst = 0; shamt = 0;

    run_md("mul_7x6", 3'd1, 2'b00, 7, 6, 0, 42, 0);
    run_md("mul_max", 3'd1, 2'b00, 32'hFFFF_FFFF,
           32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 0);
    run_md("div_100_7", 3'd2, 2'b00, 100, 7, 2, 14, 0);
    run_md("div_zero", 3'd2, 2'b00, 32'h1234, 0,
           32'h1234, 32'hFFFF_FFFF, 0);
    run_md("mul_fwd", 3'd1, 2'b10, 9, 3, 0, 27, 1);

    valid = 1; mdop = 3'd2; d1 = 1000; d2 = 3;
    repeat (10) step();
    rst = 1;
    #1;
    chk("rst_mid_stall", 64'(stall), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    mdop = 3'd4;
    @(negedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_mflo", 64'(aluout), 64'd0);
    step();
    mdop = 3'd3;
    vec("rst_mfhi", 32'd0);

    mdop = 3'd5; d1 = 32'hCAFE;
    step();
    mdop = 3'd3;
    vec("mthi_mfhi", 32'hCAFE);

    valid = 0; mdop = 3'd1; d1 = 5; d2 = 5;
    @(negedge clk);
    chk("bubble_stall", 64'(stall), 64'd0);
    step();
    @(negedge clk);
    chk("bubble_busy", 64'(busy), 64'd0);
    step();
    valid = 1; mdop = 3'd3;
    vec("bubble_hi", 32'hCAFE);
    mdop = 3'd4;
    vec("bubble_lo", 32'd0);
    mdop = 3'd0;

    v16 = 1; op16 = 3'd1; a16 = 16'hFFFF; b16 = 16'd2;
    n = 0;
    done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (!st16) done = 1;
      else begin
        n++;
        step();
      end
    end
    chk("w16_ended", 64'(done), 64'd1);
    chk("w16_stall_cycles", 64'(n), 64'd17);
    step();
    op16 = 3'd4;
    @(negedge clk);
    chk("w16_lo", 64'(alu16), 64'hFFFE);
    step();
    op16 = 3'd3;
    @(negedge clk);
    chk("w16_hi", 64'(alu16), 64'h1);
    step();
    v16 = 0; op16 = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
